// File: rtl/rc_receiver_array.sv
// N-channel RC PWM receiver: pulse-width capture, validation, scaling
// and per-channel signal-loss failsafe on the 1 MHz us_clk.
module rc_receiver_array #(
  parameter int NUM_CHANNELS  = 6,
  parameter int VAL_BIT_WIDTH = 8,
  parameter int MIN_PULSE_US  = 1000,
  parameter int MAX_PULSE_US  = 2000,
  parameter int REJECT_LO_US  = 800,
  parameter int REJECT_HI_US  = 2200,
  parameter int SCALE_SHIFT   = 2,
  parameter int TIMEOUT_US    = 50000,
  parameter int GOOD_PULSES   = 3,
  parameter int FAILSAFE_MID  = 125
) (
  input  logic                                  us_clk,
  input  logic                                  resetn,
  input  logic [NUM_CHANNELS-1:0]               pwm_in,
  output logic [NUM_CHANNELS*VAL_BIT_WIDTH-1:0] ch_val,
  output logic [NUM_CHANNELS-1:0]               ch_valid,
  output logic [NUM_CHANNELS-1:0]               update_strobe,
  output logic                                  failsafe
);

  localparam int VW = VAL_BIT_WIDTH;
  localparam int WW = $clog2(REJECT_HI_US + 2);
  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam int GW = $clog2(GOOD_PULSES + 1);

  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [WW-1:0] W_SAT = WW'(REJECT_HI_US + 1);
  localparam logic [WW-1:0] W_LO  = WW'(REJECT_LO_US);
  localparam logic [WW-1:0] W_HI  = WW'(REJECT_HI_US);
  localparam logic [WW-1:0] W_MIN = WW'(MIN_PULSE_US);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_PULSE_US);

  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_US);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_US - 1);

  localparam logic [GW-1:0] G_ONE  = GW'(1);
  localparam logic [GW-1:0] G_LAST = GW'(GOOD_PULSES - 1);

  localparam logic [VW-1:0] V_ONES = '1;

  typedef enum logic {
    LOST,
    VALID
  } state_t;

  logic [NUM_CHANNELS-1:0] valid_d;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    localparam logic [VW-1:0] FS =
      (k == 0) ? '0 : VW'(FAILSAFE_MID);

    logic          s1, s2, s3;
    logic [WW-1:0] wcnt;
    logic [TW-1:0] tcnt;
    state_t        state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [VW-1:0] val_q, val_d;
    logic          stb_q, stb_d;

    logic          rise, fall, in_range;
    logic          accept, reject, timeout;
    logic [WW-1:0] clamped, offs;
    logic [31:0]   shifted;
    logic [VW-1:0] scaled;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign in_range = (wcnt >= W_LO) && (wcnt <= W_HI);
    assign accept   = fall & in_range;
    assign reject   = fall & ~in_range;
    // Counter reaches TIMEOUT_US on this edge
    assign timeout  = (tcnt >= T_LAST);

    always_comb begin
      clamped = wcnt;
      if (wcnt < W_MIN) begin
        clamped = W_MIN;
      end else if (wcnt > W_MAX) begin
        clamped = W_MAX;
      end
      offs    = clamped - W_MIN;
      shifted = 32'(offs >> SCALE_SHIFT);
      scaled  = (shifted > 32'(V_ONES)) ?
                V_ONES : shifted[VW-1:0];
    end

    always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        s3   <= 1'b0;
        wcnt <= '0;
        tcnt <= '0;
      end else begin
        s1 <= pwm_in[k];
        s2 <= s1;
        s3 <= s2;
        if (rise) begin
          wcnt <= W_ONE;
        end else if (s2 && wcnt != W_SAT) begin
          wcnt <= wcnt + W_ONE;
        end
        if (accept) begin
          tcnt <= '0;
        end else if (tcnt != T_MAX) begin
          tcnt <= tcnt + T_ONE;
        end
      end
    end

    always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
        state_q <= LOST;
        good_q  <= '0;
        val_q   <= FS;
        stb_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        good_q  <= good_d;
        val_q   <= val_d;
        stb_q   <= stb_d;
      end
    end

    always_comb begin
      state_d = state_q;
      good_d  = good_q;
      val_d   = val_q;
      stb_d   = 1'b0;
      if (reject) begin
        good_d = '0;
      end
      unique case (state_q)
        LOST: begin
          if (accept) begin
            if (good_q == G_LAST) begin
              state_d = VALID;
              good_d  = good_q + G_ONE;
              val_d   = scaled;
              stb_d   = 1'b1;
            end else begin
              good_d = good_q + G_ONE;
            end
          end
        end
        VALID: begin
          if (accept) begin
            val_d = scaled;
            stb_d = 1'b1;
          end else if (timeout) begin
            state_d = LOST;
            good_d  = '0;
            val_d   = FS;
          end
        end
      endcase
    end

    assign valid_d[k]              = (state_d == VALID);
    assign ch_val[k*VW +: VW]      = val_q;
    assign ch_valid[k]             = (state_q == VALID);
    assign update_strobe[k]        = stb_q;
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      failsafe <= 1'b1;
    end else begin
      failsafe <= ~&valid_d;
    end
  end

endmodule

// File: tb/tb_rc_receiver_array.sv
// Randomized pulse trains on all channels checked against a
// pulse-level behavioural model of the receiver.
module tb_rc_receiver_array;

  localparam int NC = 6;
  localparam int VW = 8;
  localparam int TO = 5000;

  logic              us_clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NC-1:0]     pwm_in = '0;
  logic [NC*VW-1:0]  ch_val;
  logic [NC-1:0]     ch_valid;
  logic [NC-1:0]     update_strobe;
  logic              failsafe;

  always #5 us_clk = ~us_clk;

  rc_receiver_array #(
    .NUM_CHANNELS (NC),
    .VAL_BIT_WIDTH(VW),
    .TIMEOUT_US   (TO)
  ) dut (
    .us_clk       (us_clk),
    .resetn       (resetn),
    .pwm_in       (pwm_in),
    .ch_val       (ch_val),
    .ch_valid     (ch_valid),
    .update_strobe(update_strobe),
    .failsafe     (failsafe)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit in_rst;

  int hi_run [NC];
  bit prev_s [NC];
  int pend_at[NC];
  int pend_w [NC];
  bit m_valid[NC];
  int m_good [NC];
  int m_val  [NC];
  int m_last [NC];
  bit m_stb  [NC];
  int stb_cnt[NC];

  int gmode[NC];
  bit glvl [NC];
  int grem [NC];

  logic [63:0] prev_dut = '0;
  logic [63:0] prev_exp = '0;

  function automatic int fs_val(int c);
    return (c == 0) ? 0 : 125;
  endfunction

  function automatic int scale(int w);
    int c;
    int v;
    c = (w < 1000) ? 1000 : ((w > 2000) ? 2000 : w);
    v = (c - 1000) >> 2;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int pick_hi();
    int tbl[14];
    tbl = '{700, 799, 800, 1000, 1200, 1500, 1720,
            1750, 1800, 2000, 2100, 2200, 2201, 2300};
    if ($urandom_range(1, 0) == 1)
      return int'($urandom_range(2000, 1000));
    return tbl[$urandom_range(13, 0)];
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {3'b0, ch_val, ch_valid, update_strobe, failsafe};
  endfunction

  function automatic logic [63:0] exp_vec();
    logic [NC*VW-1:0] vv;
    logic [NC-1:0]    va;
    logic [NC-1:0]    st;
    for (int c = 0; c < NC; c++) begin
      vv[c*VW +: VW] = VW'(m_val[c]);
      va[c] = m_valid[c];
      st[c] = m_stb[c];
    end
    return {3'b0, vv, va, st, ~&va};
  endfunction

  function automatic logic [63:0] rst_vec();
    logic [NC*VW-1:0] vv;
    for (int c = 0; c < NC; c++)
      vv[c*VW +: VW] = VW'(fs_val(c));
    return {3'b0, vv, {NC{1'b0}}, {NC{1'b0}}, 1'b1};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      hi_run[c]  = 0;
      prev_s[c]  = 1'b0;
      pend_at[c] = -1;
      pend_w[c]  = 0;
      m_valid[c] = 1'b0;
      m_good[c]  = 0;
      m_val[c]   = fs_val(c);
      m_last[c]  = 0;
      m_stb[c]   = 1'b0;
    end
  endtask

  // One rising edge: outputs land two edges after the first low sample
  task automatic model_edge();
    bit acc;
    bit s;
    for (int c = 0; c < NC; c++) begin
      m_stb[c] = 1'b0;
      acc = 1'b0;
      if (pend_at[c] == cyc) begin
        pend_at[c] = -1;
        if (pend_w[c] >= 800 && pend_w[c] <= 2200) begin
          acc = 1'b1;
          m_last[c] = cyc;
          if (m_valid[c]) begin
            m_val[c] = scale(pend_w[c]);
            m_stb[c] = 1'b1;
          end else begin
            m_good[c]++;
            if (m_good[c] >= 3) begin
              m_valid[c] = 1'b1;
              m_val[c]   = scale(pend_w[c]);
              m_stb[c]   = 1'b1;
            end
          end
        end else begin
          m_good[c] = 0;
        end
      end
      if (!acc && m_valid[c] && (cyc - m_last[c] >= TO)) begin
        m_valid[c] = 1'b0;
        m_good[c]  = 0;
        m_val[c]   = fs_val(c);
      end
      s = pwm_in[c];
      if (s) begin
        hi_run[c]++;
      end else if (prev_s[c]) begin
        pend_at[c] = cyc + 2;
        pend_w[c]  = (hi_run[c] > 2201) ? 2201 : hi_run[c];
        hi_run[c]  = 0;
      end
      prev_s[c] = s;
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      if (gmode[c] == 1) begin
        pwm_in[c] = 1'b0;
      end else if (gmode[c] == 2) begin
        pwm_in[c] = 1'b1;
      end else begin
        if (grem[c] == 0) begin
          if (glvl[c]) begin
            glvl[c] = 1'b0;
            grem[c] = int'($urandom_range(900, 300));
          end else begin
            glvl[c] = 1'b1;
            grem[c] = pick_hi();
          end
        end
        grem[c]--;
        pwm_in[c] = glvl[c];
      end
    end
  endtask

  task automatic tick();
    logic [63:0] dv;
    logic [63:0] ev;
    @(posedge us_clk);
    cyc++;
    in_rst = !resetn;
    @(negedge us_clk);
    if (in_rst) model_reset();
    else model_edge();
    dv = dut_vec();
    ev = exp_vec();
    if (dv != prev_dut || ev != prev_exp || cyc % 2048 == 0)
      check("outputs", dv, ev);
    prev_dut = dv;
    prev_exp = ev;
    for (int c = 0; c < NC; c++)
      stb_cnt[c] += int'(update_strobe[c]);
    drive();
  endtask

  task automatic resume(input int c);
    gmode[c] = 0;
    glvl[c]  = 1'b0;
    grem[c]  = 300;
  endtask

  initial begin
    int s4;
    int tot;
    model_reset();
    for (int c = 0; c < NC; c++) begin
      stb_cnt[c] = 0;
      resume(c);
    end
    repeat (4) tick();
    check("reset", dut_vec(), rst_vec());
    resetn = 1'b1;

    repeat (20000) tick();

    gmode[0] = 1;
    repeat (7000) tick();
    check("ch0 lost valid", 64'(ch_valid[0]), 64'(0));
    check("ch0 lost val", 64'(ch_val[0 +: VW]), 64'(0));
    check("failsafe set", 64'(failsafe), 64'(1));
    resume(0);

    s4 = stb_cnt[4];
    gmode[4] = 2;
    repeat (11000) tick();
    check("ch4 stuck strobes", 64'(stb_cnt[4] - s4), 64'(0));
    check("ch4 stuck valid", 64'(ch_valid[4]), 64'(0));
    check("ch4 stuck val", 64'(ch_val[4*VW +: VW]), 64'(125));
    resume(4);
    repeat (6000) tick();

    for (int c = 0; c < NC; c++) gmode[c] = 1;
    repeat (400) tick();
    for (int c = 0; c < NC; c++) begin
      gmode[c] = 0;
      glvl[c]  = 1'b1;
      grem[c]  = 1500;
    end
    repeat (700) tick();
    #2 resetn = 1'b0;
    #1 model_reset();
    check("async reset", dut_vec(), rst_vec());
    repeat (5) tick();
    resetn = 1'b1;
    tot = 0;
    for (int c = 0; c < NC; c++) tot -= stb_cnt[c];
    repeat (1000) tick();
    for (int c = 0; c < NC; c++) tot += stb_cnt[c];
    check("no strobe after reset", 64'(tot), 64'(0));
    repeat (8000) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
